nios_lcd_ctrl: RTL and testbench

Parametrised Avalon-MM slave that replaces a bare LCD output port with a buffered, self-timed HD44780-style write engine. Nios II software pushes data and command bytes into an internal FIFO. A sequencer drains the FIFO and drives each byte onto the LCD bus with programmable setup, enable-pulse, hold and execution-wait times. Status is readable, so software polls instead of busy-looping on delays.

---
 rtl/nios_lcd_ctrl.sv | 166 ++++++++++++++++
 tb/tb_nios_lcd_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_lcd_ctrl.sv
// nios_lcd_ctrl: Avalon-MM slave that buffers HD44780-style LCD writes in a
// FIFO and replays each entry with programmable setup/pulse/hold/gap timing.
module nios_lcd_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 12,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned GAP_CYC   = 2000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] lcd_data,
    output logic              lcd_rs,
    output logic              lcd_en,
    output logic              lcd_rw
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_B = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = $clog2(MAXC) + 1;

    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] TMR_ONE   = CW'(1);
    localparam logic [CW-1:0] SETUP_L   = CW'(SETUP_CYC);
    localparam logic [CW-1:0] PULSE_L   = CW'(PULSE_CYC);
    localparam logic [CW-1:0] HOLD_L    = CW'(HOLD_CYC);
    localparam logic [CW-1:0] GAP_L     = CW'(GAP_CYC);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    logic [DATA_W:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   tmr_q, tmr_d;
    logic [DATA_W:0] bus_q, bus_d;

    logic wr_en, push_req, push_ok, pop, full, busy;
    logic unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign push_req     = wr_en && !address[1];
    assign full         = (count_q == FULL_CNT);
    assign push_ok      = push_req && !full;
    assign pop          = (state_q == ST_IDLE) && (count_q != '0);
    assign busy         = (count_q != '0) || (state_q != ST_IDLE);
    assign unused_wdata = ^writedata[31:DATA_W];

    assign lcd_data = bus_q[DATA_W-1:0];
    assign lcd_rs   = bus_q[DATA_W];
    assign lcd_en   = (state_q == ST_PULSE);
    assign lcd_rw   = 1'b0;

    // FIFO pointers, fill level and sticky overflow; set beats clear.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (wr_en && (address == 2'd2) && writedata[2]) ovf_d = 1'b0;
        if (push_req && full) ovf_d = 1'b1;
    end

    // Write sequencer: one shared down-counter times every phase.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bus_d   = bus_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    bus_d   = mem_q[rd_ptr_q];
                    tmr_d   = SETUP_L;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_q == TMR_ONE) begin
                    tmr_d   = PULSE_L;
                    state_d = ST_PULSE;
                end else tmr_d = tmr_q - TMR_ONE;
            end
            ST_PULSE: begin
                if (tmr_q == TMR_ONE) begin
                    tmr_d   = HOLD_L;
                    state_d = ST_HOLD;
                end else tmr_d = tmr_q - TMR_ONE;
            end
            ST_HOLD: begin
                if (tmr_q == TMR_ONE) begin
                    tmr_d   = GAP_L;
                    state_d = ST_WAIT;
                end else tmr_d = tmr_q - TMR_ONE;
            end
            ST_WAIT: begin
                if (tmr_q == TMR_ONE) state_d = ST_IDLE;
                else tmr_d = tmr_q - TMR_ONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            bus_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bus_q    <= bus_d;
        end
    end

    // FIFO storage; address 0 tags the entry as character data (rs=1).
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {address == 2'd0, writedata[DATA_W-1:0]};
    end

    // Combinational register read mux.
    always_comb begin
        readdata = '0;
        case (address)
            2'd2: begin
                readdata[0]    = busy;
                readdata[1]    = full;
                readdata[2]    = ovf_q;
                readdata[16:8] = 9'(count_q);
            end
            2'd3:    readdata[DATA_W:0] = bus_q;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_lcd_ctrl.sv
// Self-checking bench for nios_lcd_ctrl: directed scenarios plus random
// traffic, compared every cycle against a queue/timeline reference model.
module tb_nios_lcd_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int S = 1, P = 3, H = 1, G = 4;
    localparam int PERIOD = 1 + S + P + H + G;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_en, lcd_rw;

    int errors = 0;
    int checks = 0;

    nios_lcd_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SETUP_CYC(S), .PULSE_CYC(P),
        .HOLD_CYC(H), .GAP_CYC(G)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_rw(lcd_rw)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending entries plus the edge at which the
    // last entry was issued; all bus timing follows from that edge number.
    int         edge_k = 0;
    logic [8:0] mq[$];
    bit         m_ovf = 0;
    logic [8:0] m_last = '0;
    bit         m_valid = 0;
    int         m_pop_k = 0;
    int         m_next_pop = 0;
    int         m_n;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_ovf = 0; m_last = '0; m_valid = 0; m_next_pop = 0;
        end else begin
            edge_k++;
            m_n = mq.size();
            if (edge_k >= m_next_pop && m_n > 0) begin
                m_last = mq.pop_front();
                m_valid = 1;
                m_pop_k = edge_k;
                m_next_pop = edge_k + PERIOD;
            end
            if (chipselect && !write_n) begin
                if (address == 2'd2 && writedata[2]) m_ovf = 0;
                if (address <= 2'd1) begin
                    if (m_n < DEPTH) mq.push_back({address == 2'd0, writedata[7:0]});
                    else m_ovf = 1;
                end
            end
        end
    end

    int rise_k[$];
    always @(posedge lcd_en) rise_k.push_back(edge_k);

    function automatic logic m_en();
        return m_valid && edge_k >= m_pop_k + S && edge_k < m_pop_k + S + P;
    endfunction

    function automatic logic [31:0] m_status();
        logic busy;
        int n;
        n = mq.size();
        busy = (n > 0) || (m_valid && edge_k < m_pop_k + PERIOD - 1);
        return (32'(n) << 8) | (32'(m_ovf) << 2) | (32'(n == DEPTH) << 1) | 32'(busy);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("lcd_en", 32'(lcd_en), 32'(m_en()));
        chk("lcd_rs", 32'(lcd_rs), 32'(m_last[8]));
        chk("lcd_data", 32'(lcd_data), 32'(m_last[7:0]));
        chk("lcd_rw", 32'(lcd_rw), 32'd0);
        address = 2'd2; #1;
        chk("status", readdata, m_status());
        address = 2'd3; #1;
        chk("shadow", readdata, 32'(m_last));
        address = 2'd0; #1;
        chk("rd_addr0", readdata, 32'd0);
    endtask

    task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
        chipselect = w; write_n = !w; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'd0, 32'd0);
    endtask

    int n0, nr, i;

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd2; writedata = '0;
        #1;
        chk("rst_status", readdata, 32'd0);
        chk("rst_en", 32'(lcd_en), 32'd0);
        chk("rst_bus", {23'd0, lcd_rs, lcd_data}, 32'd0);
        #11 reset_n = 1'b1;
        idle(2);

        // Character write 0x41.
        rise_k.delete();
        step(1'b1, 2'd0, 32'h41);
        n0 = edge_k;
        idle(1);
        chk("data_0x41", {23'd0, lcd_rs, lcd_data}, 32'h141);
        idle(12);
        chk("rise_0x41", rise_k.size() > 0 ? rise_k[0] : -1, n0 + 2);
        address = 2'd3; #1;
        chk("addr3_0x141", readdata, 32'h141);
        address = 2'd2; #1;
        chk("idle_status", readdata, 32'd0);

        // Command write 0x01.
        rise_k.delete();
        step(1'b1, 2'd1, 32'hFFFF_FF01);
        n0 = edge_k;
        idle(12);
        chk("rise_cmd", rise_k.size() > 0 ? rise_k[0] : -1, n0 + 2);
        address = 2'd3; #1;
        chk("addr3_cmd", readdata, 32'h001);

        // Six back-to-back writes: one issued, four buffered, one dropped.
        rise_k.delete();
        for (int k = 0; k < 5; k++) step(1'b1, 2'd0, 32'(8'h30 + k));
        address = 2'd2; #1;
        chk("status_full", readdata, 32'h403);
        step(1'b1, 2'd0, 32'h35);
        address = 2'd2; #1;
        chk("status_ovf", readdata, 32'h407);
        idle(60);
        chk("pulse_cnt", rise_k.size(), 5);
        for (int k = 1; k < rise_k.size(); k++) chk("pulse_gap", rise_k[k] - rise_k[k-1], PERIOD);

        // Overflow is cleared only by writing bit 2.
        step(1'b1, 2'd2, 32'hFFFF_FFFB);
        address = 2'd2; #1;
        chk("ovf_kept", 32'(readdata[2]), 32'd1);
        step(1'b1, 2'd2, 32'h4);
        address = 2'd2; #1;
        chk("ovf_clear", 32'(readdata[2]), 32'd0);

        // Fill level while the sequencer sits in its gap wait.
        step(1'b1, 2'd0, 32'h55);
        for (i = 0; i < 20 && !(m_valid && edge_k == m_pop_k + S + P + H); i++) idle(1);
        chk("reach_wait", 32'(i < 20), 32'd1);
        for (int k = 0; k < 3; k++) step(1'b1, 2'd1, 32'(8'h60 + k));
        address = 2'd2; #1;
        chk("level3", 32'(readdata[16:8]), 32'd3);
        idle(2);
        address = 2'd2; #1;
        chk("level2", 32'(readdata[16:8]), 32'd2);
        idle(10);
        address = 2'd2; #1;
        chk("level1", 32'(readdata[16:8]), 32'd1);
        idle(30);

        // Asynchronous reset in the middle of an enable pulse.
        step(1'b1, 2'd0, 32'h77);
        step(1'b1, 2'd0, 32'h78);
        for (i = 0; i < 20 && !(m_valid && edge_k == m_pop_k + S + 1); i++) idle(1);
        chk("reach_pulse", 32'(lcd_en), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_en", 32'(lcd_en), 32'd0);
        address = 2'd2; #1;
        chk("async_status", readdata, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        nr = rise_k.size();
        idle(30);
        chk("no_pulse_after_rst", rise_k.size(), nr);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b1, 2'($urandom_range(0, 3)), $urandom);
            else
                idle(1);
        end
        idle(80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
